// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: descriptor config, engine handshake and address bus of the layer sequencer
interface layer_sequencer_if #(
    parameter int MAX_LAYERS = 16,
    parameter int AW = 13,
    parameter int WW = 9
);
    localparam int LA_W = $clog2(MAX_LAYERS);
    localparam int DESC_W = 17 + 2 * AW + 2 * WW;
    logic cfg_we;
    logic [LA_W-1:0] cfg_addr;
    logic [DESC_W-1:0] cfg_data;
    logic [LA_W:0] num_layers;
    logic GO;
    logic [3:0] eng_stop;
    logic [3:0] res_in;
    logic [3:0] eng_en;
    logic [AW-1:0] memstartp;
    logic [AW-1:0] memstartzap;
    logic [WW-1:0] memstartw;
    logic [4:0] matrix;
    logic [9:0] matrix2;
    logic bias;
    logic globmaxp_en;
    logic STOP;
    logic err;
    logic [3:0] RESULT;
    modport master (
        output cfg_we, cfg_addr, cfg_data, num_layers, GO, eng_stop, res_in,
        input eng_en, memstartp, memstartzap, memstartw, matrix, matrix2, bias, globmaxp_en,
        STOP, err, RESULT
    );
    modport slave (
        input cfg_we, cfg_addr, cfg_data, num_layers, GO, eng_stop, res_in,
        output eng_en, memstartp, memstartzap, memstartw, matrix, matrix2, bias, globmaxp_en,
        STOP, err, RESULT
    );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: walks a descriptor table of layers/passes, driving ping-pong buffer bases,
// one-hot engine enables, a per-pass watchdog and the final classification result.
module layer_sequencer #(
    parameter int MAX_LAYERS = 16,
    parameter int SIZE_address_pix = 13,
    parameter int SIZE_address_wei = 9,
    parameter int BUF_A_BASE = 0,
    parameter int BUF_B_BASE = 3136,
    parameter int TIMEOUT = 65535
) (
    input logic clk,
    input logic rst,
    layer_sequencer_if.slave bus
);
    localparam int LA_W = $clog2(MAX_LAYERS);
    localparam int AW = SIZE_address_pix;
    localparam int WW = SIZE_address_wei;
    localparam int DESC_W = 17 + 2 * AW + 2 * WW;
    localparam int O_SRC = 15;
    localparam int O_DST = O_SRC + AW;
    localparam int O_WB = O_DST + AW;
    localparam int O_WS = O_WB + WW;
    localparam int O_GM = O_WS + WW;
    localparam logic [AW-1:0] BUF_A = AW'(BUF_A_BASE);
    localparam logic [AW-1:0] BUF_B = AW'(BUF_B_BASE);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, ADV, DONE} state_t;
    state_t state, state_nx;

    logic [DESC_W-1:0] mem [MAX_LAYERS];
    logic [DESC_W-1:0] desc, rd;
    logic [LA_W:0] layer, nl;
    logic [7:0] pass, passes_m1;
    logic [1:0] op;
    logic [3:0] res;
    logic [31:0] wd;
    logic bufsel, stop, idle, hit, expire, more, last;

    assign rd = mem[layer[LA_W-1:0]];
    assign op = desc[1:0];
    assign passes_m1 = desc[14:7] == 8'd0 ? 8'd0 : desc[14:7] - 8'd1;
    assign idle = state == IDLE || state == DONE;
    assign hit = bus.eng_stop[op];
    assign expire = TIMEOUT != 0 && wd == 32'(TIMEOUT - 1);
    assign more = pass != passes_m1;
    assign last = layer + {{LA_W{1'b0}}, 1'b1} == nl;
    assign bus.STOP = stop;
    assign bus.RESULT = stop ? res : 4'hF;
    assign bus.matrix2 = {5'd0, bus.matrix} * {5'd0, bus.matrix};

    always_ff @(posedge clk)
        if (bus.cfg_we && idle)
            mem[bus.cfg_addr] <= bus.cfg_data;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = !bus.GO ? state : bus.num_layers == '0 ? DONE : FETCH;
            FETCH: state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT: state_nx = hit ? ADV : expire ? DONE : WAIT;
            ADV: state_nx = more ? ISSUE : last ? DONE : FETCH;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.eng_en <= '0;
            bus.memstartp <= '0;
            bus.memstartzap <= '0;
            bus.memstartw <= '0;
            bus.matrix <= 5'd28;
            bus.bias <= 1'b0;
            bus.globmaxp_en <= 1'b0;
            bus.err <= 1'b0;
            stop <= 1'b1;
            res <= 4'hF;
            desc <= '0;
            layer <= '0;
            nl <= '0;
            pass <= '0;
            bufsel <= 1'b0;
            wd <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    stop <= !bus.GO;
                    if (bus.GO) begin
                        bus.err <= 1'b0;
                        res <= 4'hF;
                        layer <= '0;
                        nl <= bus.num_layers;
                        pass <= '0;
                        bufsel <= 1'b0;
                    end
                end
                FETCH: begin
                    desc <= rd;
                    pass <= '0;
                    bus.memstartp <= bufsel ? BUF_B : BUF_A;
                    bus.memstartzap <= bufsel ? BUF_A : BUF_B;
                    bus.memstartw <= rd[O_WB +: WW];
                    bus.matrix <= rd[6:2];
                end
                ISSUE: begin
                    bus.eng_en <= 4'd1 << op;
                    bus.bias <= pass == passes_m1;
                    bus.globmaxp_en <= desc[O_GM];
                    wd <= '0;
                end
                WAIT: begin
                    // a stop arriving on the expiry cycle wins over the watchdog
                    if (hit || expire) begin
                        bus.eng_en <= '0;
                        bus.bias <= 1'b0;
                        bus.globmaxp_en <= 1'b0;
                    end
                    if (!hit && expire) begin
                        bus.err <= 1'b1;
                        stop <= 1'b1;
                        res <= 4'hE;
                    end
                    wd <= wd + 32'd1;
                end
                ADV: begin
                    if (more) begin
                        pass <= pass + 8'd1;
                        bus.memstartp <= bus.memstartp + desc[O_SRC +: AW];
                        bus.memstartzap <= bus.memstartzap + desc[O_DST +: AW];
                        bus.memstartw <= bus.memstartw + desc[O_WS +: WW];
                    end else begin
                        if (op == 2'd3)
                            res <= bus.res_in;
                        bufsel <= bufsel ^ ~desc[O_GM + 1];
                        layer <= layer + {{LA_W{1'b0}}, 1'b1};
                        stop <= last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
